// File: rtl/aes_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : aes_out_serializer
// Description : Captures 128-bit ciphertext blocks from AES_top on a one-cycle
//               valid pulse, buffers them in a small block FIFO and streams
//               each block as four 32-bit words over a valid/ready interface.
//               A block arriving while the buffer is full (and no same-edge
//               pop frees an entry) is dropped and a sticky overflow flag is
//               raised.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEPTH   number of buffered 128-bit blocks (2 or 4)
//   LVL_W   width of buf_level, equal to $clog2(DEPTH)+1
// Ports:
//   AES_clk             in   single clock
//   AES_rst             in   synchronous active-high reset
//   AES_data_out_valid  in   one-cycle pulse, AES_data_out valid
//   AES_data_out        in   128-bit ciphertext block
//   ser_ready           in   consumer accepts a word this cycle
//   ser_valid           out  ser_data holds a valid word
//   ser_data            out  current 32-bit output word
//   ser_last            out  current word is the 4th word of its block
//   ser_overflow        out  sticky: a block was dropped
//   buf_level           out  blocks currently buffered (0..DEPTH)
// Configuration macro:
//   AES_OUT_LSW_FIRST_EN  defined -> least-significant word sent first;
//                         undefined -> most-significant word sent first.
// ============================================================================
module aes_out_serializer #(
    parameter int DEPTH = 2,
    parameter int LVL_W = 2
) (
    input  logic               AES_clk,
    input  logic               AES_rst,
    input  logic               AES_data_out_valid,
    input  logic [127:0]       AES_data_out,
    input  logic               ser_ready,
    output logic               ser_valid,
    output logic [31:0]        ser_data,
    output logic               ser_last,
    output logic               ser_overflow,
    output logic [LVL_W-1:0]   buf_level
);

    localparam int c_PTR_W = $clog2(DEPTH);

    // Reject unsupported configurations at elaboration time.
    generate
        if ((DEPTH != 2 && DEPTH != 4) || (LVL_W != $clog2(DEPTH) + 1)) begin : g_bad_param
            $error("aes_out_serializer: DEPTH must be 2 or 4 and LVL_W must be $clog2(DEPTH)+1");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [127:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [LVL_W-1:0]     r_count;
    logic [1:0]           r_widx;
    logic                 r_overflow;

    logic                 w_full;
    logic                 w_xfer;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [LVL_W-1:0]     w_count_next;
    logic [1:0]           w_widx_next;

    logic [127:0]         w_head;
    logic [1:0]           w_lane;
    logic [31:0]          w_word;

    // ------------------------------------------------------------------------
    // Next-state, handshake and FIFO bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_widx_next  = r_widx;
        w_full       = (r_count == LVL_W'(DEPTH));
        w_xfer       = (r_state == S_SEND) && ser_ready;
        w_pop        = w_xfer && (r_widx == 2'd3);
        // A full buffer can still take a block if the head leaves on this edge.
        w_push       = AES_data_out_valid && (!w_full || w_pop);
        w_drop       = AES_data_out_valid && w_full && !w_pop;
        w_count_next = r_count;

        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + LVL_W'(1);
            2'b01:   w_count_next = r_count - LVL_W'(1);
            default: w_count_next = r_count;
        endcase

        // widx wraps 3 -> 0 naturally, which coincides with the head pop.
        if (w_xfer) begin
            w_widx_next = r_widx + 2'd1;
        end

        // The state is chosen from the post-edge occupancy so that a block
        // captured into an empty buffer is presented on the very next cycle
        // and consecutive blocks stream without a bubble.
        case (r_state)
            S_IDLE: begin
                if (w_count_next != '0) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_pop && (w_count_next == '0)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO control registers and sticky overflow
    // ------------------------------------------------------------------------
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_widx     <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_widx  <= w_widx_next;
            // DEPTH is a power of two, so pointers wrap by plain overflow.
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Block storage. Not reset: an entry is only read after being written,
    // and the output word is forced to zero while nothing is being sent.
    // A push during reset is blocked so the coincident block is discarded.
    // ------------------------------------------------------------------------
    always_ff @(posedge AES_clk) begin
        if (w_push && !AES_rst) begin
            r_mem[r_wptr] <= AES_data_out;
        end
    end

    // ------------------------------------------------------------------------
    // Head/word select. w_lane is the 32-bit lane number counted from the
    // least-significant end of the block.
    // ------------------------------------------------------------------------
    always_comb begin
        w_head = r_mem[r_rptr];
`ifdef AES_OUT_LSW_FIRST_EN
        w_lane = r_widx;
`else
        w_lane = ~r_widx;
`endif
        case (w_lane)
            2'd0:    w_word = w_head[31:0];
            2'd1:    w_word = w_head[63:32];
            2'd2:    w_word = w_head[95:64];
            default: w_word = w_head[127:96];
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: registered state through the head/word mux only.
    // ------------------------------------------------------------------------
    assign ser_valid    = (r_state == S_SEND);
    assign ser_data     = ser_valid ? w_word : 32'd0;
    assign ser_last     = ser_valid && (r_widx == 2'd3);
    assign ser_overflow = r_overflow;
    assign buf_level    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_aes_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_out_serializer
// Description : Scoreboard bench for aes_out_serializer (DEPTH=2). Expected
//               words are queued when a block is driven and compared as the
//               DUT transfers them; stall stability is checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_out_serializer;

    localparam int DEPTH = 2;
    localparam int LVL_W = 2;

    logic               clk_r;
    logic               rst;
    logic               dvalid;
    logic [127:0]       ddata;
    logic               ready;
    logic               ser_valid;
    logic [31:0]        ser_data;
    logic               ser_last;
    logic               ser_overflow;
    logic [LVL_W-1:0]   buf_level;

    int errors = 0;
    int checks = 0;

    logic [32:0] sb [$];

    aes_out_serializer #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_dut (
        .AES_clk            (clk_r),
        .AES_rst            (rst),
        .AES_data_out_valid (dvalid),
        .AES_data_out       (ddata),
        .ser_ready          (ready),
        .ser_valid          (ser_valid),
        .ser_data           (ser_data),
        .ser_last           (ser_last),
        .ser_overflow       (ser_overflow),
        .buf_level          (buf_level)
    );

    initial clk_r = 1'b0;
    always #5 clk_r = ~clk_r;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [127:0] b, input int i);
`ifdef AES_OUT_LSW_FIRST_EN
        return b[i*32 +: 32];
`else
        return b[(3-i)*32 +: 32];
`endif
    endfunction

    task automatic push_block(input logic [127:0] b);
        for (int i = 0; i < 4; i++) begin
            sb.push_back({(i == 3), exp_word(b, i)});
        end
    endtask

    task automatic tick();
        @(posedge clk_r);
        #1;
    endtask

    task automatic pulse(input logic [127:0] b, input bit accepted);
        dvalid = 1'b1;
        ddata  = b;
        if (accepted) push_block(b);
        tick();
        dvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || ser_valid) && n < 200) begin
            @(negedge clk_r);
            n++;
        end
        chk(tag, sb.size(), 0);
        chk(tag, ser_valid, 1'b0);
        tick();
    endtask

    // Transfer monitor: ready is driven just after the rising edge, so the
    // value seen on the falling edge is the one the next edge samples.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    always @(negedge clk_r) begin
        logic [32:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", ser_valid, 1'b1);
                chk("stall_data", ser_data, prev_data);
                chk("stall_last", ser_last, prev_last);
            end
            if (ser_valid && ready) begin
                if (sb.size() == 0) begin
                    chk("extra_word", {ser_last, ser_data}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("word", ser_data, e[31:0]);
                    chk("last", ser_last, e[32]);
                end
            end
            prev_stall = ser_valid && !ready;
            prev_data  = ser_data;
            prev_last  = ser_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int          bp_pat [7]  = '{1, 0, 0, 1, 0, 1, 1};
    int          lvl_seq [9] = '{1, 2, 2, 2, 1, 1, 1, 1, 0};
    logic [127:0] blk_a;
    logic [127:0] blk_b;
    logic [127:0] blk_c;

    initial begin
        blk_a = 128'h00112233_44556677_8899aabb_ccddeeff;
        blk_b = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        blk_c = 128'h11111111_22222222_33333333_44444444;

        rst = 1'b1; dvalid = 1'b0; ddata = '0; ready = 1'b0;
        tick();
        tick();
        @(negedge clk_r);
        chk("rst_valid", ser_valid, 1'b0);
        chk("rst_data", ser_data, 32'd0);
        chk("rst_last", ser_last, 1'b0);
        chk("rst_ovf", ser_overflow, 1'b0);
        chk("rst_level", buf_level, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single block, ready high: four consecutive words one cycle after capture.
        ready = 1'b1;
        pulse(blk_a, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_r);
            chk("t1_valid", ser_valid, 1'b1);
            if (i == 0) chk("t1_first", ser_data, exp_word(blk_a, 0));
            tick();
        end
        @(negedge clk_r);
        chk("t1_idle", ser_valid, 1'b0);
        tick();

        // Backpressure with a fixed ready pattern.
        pulse(blk_a, 1'b1);
        for (int i = 0; i < 7; i++) begin
            ready = bp_pat[i][0];
            tick();
        end
        ready = 1'b1;
        drain("t2_drain");
        chk("t2_level", buf_level, 0);

        // Back-to-back blocks on consecutive cycles.
        dvalid = 1'b1; ddata = blk_a; push_block(blk_a);
        tick();
        ddata = blk_b; push_block(blk_b);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_r);
            chk("t3_level", buf_level, lvl_seq[i]);
            chk("t3_valid", ser_valid, (i < 8));
            tick();
            dvalid = 1'b0;
        end
        drain("t3_drain");

        // Overflow: three blocks while stalled, the third is dropped.
        ready = 1'b0;
        pulse(blk_a, 1'b1);
        pulse(blk_b, 1'b1);
        @(negedge clk_r);
        chk("t4_ovf_before", ser_overflow, 1'b0);
        tick();
        pulse(blk_c, 1'b0);
        @(negedge clk_r);
        chk("t4_ovf", ser_overflow, 1'b1);
        chk("t4_level", buf_level, 2);
        chk("t4_head", ser_data, exp_word(blk_a, 0));
        tick();
        ready = 1'b1;
        drain("t4_drain");
        chk("t4_ovf_sticky", ser_overflow, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk_r);
        chk("t4_ovf_clr", ser_overflow, 1'b0);
        tick();

        // Simultaneous push/pop while full.
        ready = 1'b0;
        pulse(blk_a, 1'b1);
        pulse(blk_b, 1'b1);
        ready = 1'b1;
        tick();
        tick();
        tick();
        pulse(blk_c, 1'b1);
        @(negedge clk_r);
        chk("t5_level", buf_level, 2);
        chk("t5_ovf", ser_overflow, 1'b0);
        tick();
        drain("t5_drain");
        chk("t5_ovf_end", ser_overflow, 1'b0);
        chk("t5_level_end", buf_level, 0);

        // Reset after two words; a coincident pulse must be ignored.
        pulse(blk_b, 1'b1);
        tick();
        tick();
        rst = 1'b1; dvalid = 1'b1; ddata = blk_c;
        sb.delete();
        tick();
        rst = 1'b0; dvalid = 1'b0;
        @(negedge clk_r);
        chk("t6_valid", ser_valid, 1'b0);
        chk("t6_level", buf_level, 0);
        chk("t6_ovf", ser_overflow, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk_r);
            chk("t6_quiet", ser_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
